// File: rtl/pipe_hazard_pkg.sv
// Shared types for the pipeline hazard controller: scoreboard entry layout
// and the forwarding select value that means "read the register file".
package pipe_hazard_pkg;

    // Scoreboard entries carry register numbers up to this width; narrower
    // REG_W values are zero-extended into the field.
    localparam int REG_W_MAX = 8;
    localparam int FWD_RF    = 0;

    typedef struct packed {
        logic                 valid;
        logic [REG_W_MAX-1:0] wreg;
        logic                 regwrite;
        logic                 is_load;
    } sb_entry_t;

endpackage

// File: rtl/pipe_hazard_ctl_hazard_match.sv
// Priority match of one ID source register against the in-flight scoreboard:
// the youngest matching writer wins and decides forwarding and load-use stall.
module hazard_match
    import pipe_hazard_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int FW       = $clog2(DEPTH + 1)
) (
    input  sb_entry_t [DEPTH-1:0] entries,
    input  logic [REG_W-1:0]      src,
    input  logic                  use_src,
    output logic [FW-1:0]         fwd,
    output logic                  load_hazard
);

    logic [REG_W_MAX-1:0] src_ext;

    assign src_ext = REG_W_MAX'(src);

    // Walk oldest to youngest so the last hit (lowest index) is what remains.
    always_comb begin
        fwd         = FW'(FWD_RF);
        load_hazard = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (use_src && entries[k].valid && entries[k].regwrite &&
                entries[k].wreg != '0 && entries[k].wreg == src_ext) begin
                fwd         = FW'(k + 1);
                load_hazard = entries[k].is_load && (k < LOAD_LAT);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Pipeline hazard controller: scoreboard of in-flight writers, operand
// forwarding selects, load-use stall and branch flush. Define HAZ_PERF_CNT_EN
// to build the saturating stall/flush performance counters.
module pipe_hazard_ctl
    import pipe_hazard_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int BR_STAGE = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         id_valid,
    input  logic [REG_W-1:0]             id_rs,
    input  logic [REG_W-1:0]             id_rt,
    input  logic                         id_use_rs,
    input  logic                         id_use_rt,
    input  logic [REG_W-1:0]             id_wreg,
    input  logic                         id_regwrite,
    input  logic                         id_is_load,
    input  logic                         ext_hold,
    input  logic                         br_taken,
    output logic [$clog2(DEPTH+1)-1:0]   fwd_a,
    output logic [$clog2(DEPTH+1)-1:0]   fwd_b,
    output logic                         stall,
    output logic                         flush_if_id,
    output logic                         flush_id,
    output logic [15:0]                  stall_cnt,
    output logic [15:0]                  flush_cnt
);

    localparam int FW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  sb_vld;
    logic [REG_W-1:0]  sb_wreg [DEPTH];
    logic [DEPTH-1:0]  sb_regwrite;
    logic [DEPTH-1:0]  sb_is_load;
    sb_entry_t [DEPTH-1:0] entries;

    logic haz_a;
    logic haz_b;
    logic flush;

    for (genvar k = 0; k < DEPTH; k++) begin : g_entry
        assign entries[k] = {sb_vld[k], REG_W_MAX'(sb_wreg[k]), sb_regwrite[k], sb_is_load[k]};
    end

    hazard_match #(
        .REG_W    (REG_W),
        .DEPTH    (DEPTH),
        .LOAD_LAT (LOAD_LAT),
        .FW       (FW)
    ) u_match_rs (
        .entries     (entries),
        .src         (id_rs),
        .use_src     (id_use_rs),
        .fwd         (fwd_a),
        .load_hazard (haz_a)
    );

    hazard_match #(
        .REG_W    (REG_W),
        .DEPTH    (DEPTH),
        .LOAD_LAT (LOAD_LAT),
        .FW       (FW)
    ) u_match_rt (
        .entries     (entries),
        .src         (id_rt),
        .use_src     (id_use_rt),
        .fwd         (fwd_b),
        .load_hazard (haz_b)
    );

    // A held pipeline cannot redirect, so the branch waits for release.
    assign flush       = br_taken && !ext_hold;
    assign flush_if_id = flush;
    assign flush_id    = flush;
    assign stall       = id_valid && (haz_a || haz_b) && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_vld <= '0;
        end else if (!ext_hold) begin
            sb_vld[0] <= id_valid && !stall && !flush;
            for (int k = 1; k < DEPTH; k++) begin
                sb_vld[k] <= sb_vld[k-1] && !(flush && (k - 1 < BR_STAGE));
            end
        end
    end

    // Payload needs no reset: every consumer is gated by the valid bit.
    always_ff @(posedge clk) begin
        if (!ext_hold) begin
            sb_wreg[0]     <= id_wreg;
            sb_regwrite[0] <= id_regwrite;
            sb_is_load[0]  <= id_is_load;
            for (int k = 1; k < DEPTH; k++) begin
                sb_wreg[k]     <= sb_wreg[k-1];
                sb_regwrite[k] <= sb_regwrite[k-1];
                sb_is_load[k]  <= sb_is_load[k-1];
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && !ext_hold && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (flush && flush_cnt != 16'hFFFF) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: doc/pipe_hazard_ctl.md
PIPE_HAZARD_CTL -- requirements
Module: pipe_hazard_ctl

Interface
REQ-001 Parameter REG_W, default 5: register-number width.
REQ-002 Parameter DEPTH, default 3: in-flight scoreboard entries after ID (entry 0 = EX, 1 = MEM, 2 = WB).
REQ-003 Parameter LOAD_LAT, default 1: a load in entry k is forwardable only when k >= LOAD_LAT.
REQ-004 Parameter BR_STAGE, default 1: entry index at which a branch is resolved.
REQ-005 Port clk, input, 1: single clock; all state is updated on its rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-high reset.
REQ-007 Port id_valid, input, 1: the ID stage holds a real instruction.
REQ-008 Ports id_rs and id_rt, input, REG_W each: ID source registers.
REQ-009 Ports id_use_rs and id_use_rt, input, 1 each: the instruction reads that source.
REQ-010 Ports id_wreg (input, REG_W), id_regwrite (input, 1) and id_is_load (input, 1): the ID instruction's write target and type.
REQ-011 Port ext_hold, input, 1: external freeze, e.g. a memory wait.
REQ-012 Port br_taken, input, 1: the branch in entry BR_STAGE resolved taken.
REQ-013 Ports fwd_a and fwd_b, output, $clog2(DEPTH+1) each: 0 selects the register file; k+1 selects entry k.
REQ-014 Port stall, output, 1: hold PC and IF/ID, and inject a bubble into entry 0.
REQ-015 Ports flush_if_id and flush_id, output, 1 each: kill the IF and ID instructions.
REQ-016 Ports stall_cnt and flush_cnt, output, 16 each: performance counters (see Configuration).

Function
REQ-017 Each entry SHALL hold {valid, wreg, regwrite, is_load}.
REQ-018 An entry matches a source when: valid, regwrite, wreg != 0, wreg == source, and the source's use flag is set.
REQ-019 fwd_a and fwd_b SHALL select the lowest-index (youngest) matching entry, else 0. They are combinational from state and inputs, with zero latency.
REQ-020 stall SHALL be 1 when id_valid and the youngest match for either source is a load at index < LOAD_LAT.
REQ-021 While stall=1, fwd_a and fwd_b are don't-care, and the bench SHALL NOT check them.
REQ-022 Advance cycle (ext_hold=0): entry k+1 <= entry k, and entry DEPTH-1 retires.
REQ-023 On an advance cycle, entry 0 <= the ID instruction if id_valid && !stall && !flush; otherwise entry 0 <= a bubble (valid=0).
REQ-024 flush_if_id = flush_id = br_taken && !ext_hold.
REQ-025 On a flush cycle, entries with index < BR_STAGE SHALL have valid cleared as they advance.
REQ-026 Flush overrides stall: stall output = 0 whenever flush_id = 1.
REQ-027 When ext_hold=1, the scoreboard SHALL freeze. stall and forwarding outputs still evaluate; br_taken is ignored, and its source holds it until release.
REQ-028 Entries with wreg = 0 SHALL never forward or stall.
REQ-029 Back-to-back identical writers SHALL forward the youngest.
REQ-030 DEPTH = 1 SHALL be legal.
REQ-031 LOAD_LAT >= DEPTH means loads never forward; the stall holds until the load retires.

Reset
REQ-032 rst=1 SHALL asynchronously clear every entry's valid bit and zero both counters.
REQ-033 During reset, outputs SHALL be: fwd_a = fwd_b = 0, stall = 0, flush_* = br_taken-derived.
REQ-034 A reset mid-stall SHALL drop the pending load; the first cycle after release has no hazards.

Configuration
REQ-035 With macro HAZ_PERF_CNT_EN defined, stall_cnt SHALL increment on each cycle with stall=1 && !ext_hold, and saturate at 16'hFFFF.
REQ-036 With HAZ_PERF_CNT_EN defined, flush_cnt SHALL increment on each flush cycle, and saturate at 16'hFFFF.
REQ-037 Without HAZ_PERF_CNT_EN, both counters SHALL be constant 0 and no counter flops SHALL be inferred.

Structure
REQ-038 Package pipe_hazard_pkg SHALL hold the sb_entry_t struct and the FWD_RF = 0 constant.
REQ-039 Sub-module hazard_match SHALL implement the per-source priority match. It is instantiated twice, once for rs and once for rt.
REQ-040 The scoreboard shift register and the counters SHALL reside in the top module.

Verification
REQ-041 ALU-ALU forwarding: issue add r3 in ID, then next cycle issue a reader of r3 -> fwd_a = 1 and stall = 0.
REQ-042 Load-use: issue lw r5, then an immediate reader of r5 (LOAD_LAT=1) -> stall = 1 for 1 cycle, then fwd = 2 and entry 0 = bubble.
REQ-043 Taken branch: br_taken=1 with an instruction in entry 0 -> flush_id = 1, entry 0 and ID killed, flush_cnt + 1.
REQ-044 Hold and flush: ext_hold=1 with br_taken=1 -> no flush and scoreboard unchanged. On release -> flush_id = 1 in that cycle.
REQ-045 r0 and youngest-wins: writes to r0 -> fwd = 0. Two writers of r7 in entries 0 and 1 -> fwd = 1.
REQ-046 Reset during a load-use stall -> stall = 0 immediately and counters = 0. With the macro undefined, the counters read 0 throughout.
